// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - 640x480 VGA raster timing generator with registered, blanked pixel output
module vga_scan_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] Red_in,
  input  logic [7:0] Green_in,
  input  logic [7:0] Blue_in,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_Clk,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       Frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DCW     = $clog2(CLK_DIV);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic [DCW-1:0] DC_LAST    = DCW'(CLK_DIV - 1);
  localparam logic [DCW-1:0] DC_PRE_SET = DCW'(CLK_DIV / 2 - 1);

  logic [DCW-1:0] dc;
  logic [9:0]     hc;
  logic [9:0]     vc;
  logic           pix_ce;
  logic           h_last;
  logic           v_last;
  logic           vis;
  logic           hs_act;
  logic           vs_act;

  assign pix_ce = (dc == DC_LAST);
  assign h_last = (hc == H_LAST);
  assign v_last = (vc == V_LAST);
  assign vis    = (hc < H_VIS) && (vc < V_VIS);
  assign hs_act = (hc >= HS_START) && (hc < HS_END);
  assign vs_act = (vc >= VS_START) && (vc < VS_END);

  assign DrawX      = hc;
  assign DrawY      = vc;
  assign VGA_SYNC_N = 1'b0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dc          <= '0;
      hc          <= '0;
      vc          <= '0;
      VGA_Clk     <= 1'b0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      Frame_start <= 1'b0;
    end else begin
      dc <= pix_ce ? '0 : dc + DCW'(1);

      // Pixel clock rises half a pixel after each output update so the DAC samples settled data
      if (pix_ce)
        VGA_Clk <= 1'b0;
      else if (dc == DC_PRE_SET)
        VGA_Clk <= 1'b1;

      Frame_start <= pix_ce && h_last && v_last;

      if (pix_ce) begin
        hc <= h_last ? '0 : hc + 10'd1;
        if (h_last)
          vc <= v_last ? '0 : vc + 10'd1;

        VGA_HS      <= ~hs_act;
        VGA_VS      <= ~vs_act;
        VGA_BLANK_N <= vis;
        VGA_R       <= vis ? Red_in   : 8'h00;
        VGA_G       <= vis ? Green_in : 8'h00;
        VGA_B       <= vis ? Blue_in  : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen on a reduced raster at two pixel dividers
module tb_vga_scan_gen;

  localparam int HV = 20, HF = 3, HS = 4, HB = 5;
  localparam int VV = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [7:0] r_in = 8'h00;
  logic [7:0] g_in = 8'h00;
  logic [7:0] b_in = 8'h00;

  logic [9:0] dx [2];
  logic [9:0] dy [2];
  logic       vclk [2];
  logic       hs [2];
  logic       vs [2];
  logic       bl [2];
  logic       sy [2];
  logic       fs [2];
  logic [7:0] vr [2];
  logic [7:0] vg [2];
  logic [7:0] vb [2];

  int errors = 0;
  int checks = 0;

  // Reference model state: Clk edges since reset release, and last registered pixel outputs
  int n [2];
  int e_hs [2];
  int e_vs [2];
  int e_bl [2];
  int e_r [2];
  int e_g [2];
  int e_b [2];
  int e_fs [2];

  always #5 Clk = ~Clk;

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(2)
  ) dut0 (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(dx[0]), .DrawY(dy[0]), .VGA_Clk(vclk[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bl[0]), .VGA_SYNC_N(sy[0]),
    .VGA_R(vr[0]), .VGA_G(vg[0]), .VGA_B(vb[0]), .Frame_start(fs[0])
  );

  vga_scan_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(3)
  ) dut1 (
    .Clk(Clk), .Reset_n(Reset_n),
    .Red_in(r_in), .Green_in(g_in), .Blue_in(b_in),
    .DrawX(dx[1]), .DrawY(dy[1]), .VGA_Clk(vclk[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bl[1]), .VGA_SYNC_N(sy[1]),
    .VGA_R(vr[1]), .VGA_G(vg[1]), .VGA_B(vb[1]), .Frame_start(fs[1])
  );

  function automatic int div_of(int i);
    return (i == 0) ? 2 : 3;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s div=%0d edge=%0d got=%0h exp=%0h", tag, div_of(i), n[i], got, expv);
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 2; i++) begin
      int d;
      int p;
      int hx;
      int vy;
      int vis;
      d = div_of(i);
      if (!Reset_n) begin
        n[i] = 0;
        e_hs[i] = 1; e_vs[i] = 1; e_bl[i] = 0;
        e_r[i] = 0; e_g[i] = 0; e_b[i] = 0; e_fs[i] = 0;
      end else begin
        p = n[i] / d;
        e_fs[i] = 0;
        if (n[i] % d == d - 1) begin
          hx = p % HT;
          vy = (p / HT) % VT;
          vis = (hx < HV && vy < VV) ? 1 : 0;
          e_hs[i] = (hx >= HV + HF && hx < HV + HF + HS) ? 0 : 1;
          e_vs[i] = (vy >= VV + VF && vy < VV + VF + VS) ? 0 : 1;
          e_bl[i] = vis;
          e_r[i] = vis ? int'(r_in) : 0;
          e_g[i] = vis ? int'(g_in) : 0;
          e_b[i] = vis ? int'(b_in) : 0;
          e_fs[i] = ((p + 1) % (HT * VT) == 0) ? 1 : 0;
        end
        n[i]++;
      end
    end
    @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      int d;
      int p;
      d = div_of(i);
      p = n[i] / d;
      chk("drawx",   i, 32'(dx[i]),   32'(p % HT));
      chk("drawy",   i, 32'(dy[i]),   32'((p / HT) % VT));
      chk("vga_clk", i, 32'(vclk[i]), 32'((n[i] % d) >= d / 2));
      chk("hs",      i, 32'(hs[i]),   32'(e_hs[i]));
      chk("vs",      i, 32'(vs[i]),   32'(e_vs[i]));
      chk("blank_n", i, 32'(bl[i]),   32'(e_bl[i]));
      chk("sync_n",  i, 32'(sy[i]),   32'd0);
      chk("red",     i, 32'(vr[i]),   32'(e_r[i]));
      chk("green",   i, 32'(vg[i]),   32'(e_g[i]));
      chk("blue",    i, 32'(vb[i]),   32'(e_b[i]));
      chk("frame",   i, 32'(fs[i]),   32'(e_fs[i]));
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;

    r_in = 8'hFF; g_in = 8'h55; b_in = 8'h00;
    repeat (1300) tick();

    repeat (2600) begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
    end

    repeat (300) begin
      r_in = dx[0][7:0];
      tick();
    end

    repeat (1000 + $urandom_range(0, 200)) begin
      r_in = 8'($urandom);
      tick();
    end
    Reset_n = 1'b0;
    tick();
    Reset_n = 1'b1;
    repeat (2000) begin
      r_in = 8'($urandom);
      g_in = 8'($urandom);
      b_in = 8'($urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Raster timing generator and pixel output stage for the 640x480 @ 60 Hz VGA path.
- Produces the DrawX/DrawY scan coordinates that the colour mapper consumes.
- Accepts the mapper's combinational RGB, blanks it outside the visible area and registers it together with HS/VS/BLANK so the DAC sees aligned signals.
- Sits between the colour mapper and the VGA DAC pins at top level. Also emits a once-per-frame pulse for the motion logic.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- CLK_DIV, 2, Clk cycles per pixel; must be >= 2

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  synchronous reset, active-low
- Red_in, Green_in, Blue_in  in  8 each  pixel colour from the colour mapper for the current DrawX/DrawY
- DrawX  out  10  current horizontal scan count
- DrawY  out  10  current vertical scan count
- VGA_Clk  out  1  pixel clock to the DAC
- VGA_HS  out  1  horizontal sync, active-low
- VGA_VS  out  1  vertical sync, active-low
- VGA_BLANK_N  out  1  low outside the visible area
- VGA_SYNC_N  out  1  constant 0
- VGA_R, VGA_G, VGA_B  out  8 each  registered, blanked colour
- Frame_start  out  1  one-Clk pulse at start of each frame

Behaviour:
- Constants: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Pixel divider:
  - dc counts 0..CLK_DIV-1, wrapping.
  - pix_ce = (dc == CLK_DIV-1).
  - All pixel-rate state below updates only on Clk edges where pix_ce = 1.
- Counters:
  - hc: 0..H_TOTAL-1, increments on pix_ce, wraps to 0.
  - vc: increments only when hc wraps; itself wraps 0..V_TOTAL-1.
  - DrawX = hc and DrawY = vc, driven directly from the counter registers (no extra delay).
- Decode from the current hc/vc:
  - vis = (hc < H_VISIBLE) && (vc < V_VISIBLE).
  - hs_act = hc in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. [656, 751].
  - vs_act = vc in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. [490, 491].
- Output stage, one pixel of latency. On pix_ce, register:
  - VGA_HS <= ~hs_act
  - VGA_VS <= ~vs_act
  - VGA_BLANK_N <= vis
  - VGA_R/G/B <= vis ? Red_in/Green_in/Blue_in : 0
  - Result: outputs describe the pixel whose coordinates were on DrawX/DrawY during the preceding pixel period.
- VGA_Clk:
  - Registered; cleared on every pix_ce edge; set on the edge where dc becomes CLK_DIV/2.
  - For CLK_DIV = 2 this is a 25 MHz square wave whose rising edge falls mid-way between output updates.
- Frame_start:
  - Registered; high for exactly one Clk on the edge where hc and vc both wrap to 0.
  - Low at all other times.
- Reset (Reset_n sampled low at a Clk edge, including mid-frame):
  - dc = hc = vc = 0, VGA_Clk = 0, VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, RGB = 0, Frame_start = 0.
  - The first pix_ce occurs CLK_DIV-1 edges after Reset_n returns high.
  - No Frame_start pulse is generated for the reset-forced (0,0).
- Red_in/Green_in/Blue_in are sampled only on pix_ce; values outside vis are ignored.

Test Plan:
1. Hold Reset_n low 3 Clk -> DrawX = DrawY = 0, VGA_HS = VGA_VS = 1, VGA_BLANK_N = 0, RGB = 0, Frame_start = 0. Release -> DrawX = 1 after exactly 2 Clk.
2. Run one line -> VGA_HS low for exactly 96 pixels (192 Clk), falling on the pix_ce edge after DrawX = 656. Line period 1600 Clk. DrawY increments when DrawX wraps 799 -> 0.
3. Run a full frame -> VGA_VS low for exactly 2 lines (3200 Clk) starting after DrawY = 490. Frame_start pulses every 840000 Clk, one Clk wide.
4. Drive Red_in = 8'hFF, Green_in = 8'h55, Blue_in = 8'h00 constant -> outputs FF/55/00 with BLANK_N = 1 at pixels 0..639 of lines 0..479. RGB = 0 with BLANK_N = 0 at DrawX = 640..799 and at DrawY >= 480.
5. Drive Red_in = DrawX[7:0] -> VGA_R equals the previous pixel's DrawX[7:0] at each pix_ce edge (one-pixel latency, no skew against VGA_HS).
6. Assert Reset_n low for 1 Clk at DrawX = 300, DrawY = 200 -> all outputs take reset values on that edge and the scan restarts from (0,0) with no Frame_start pulse. The first Frame_start arrives 840000 Clk after the restart.
